// File: rtl/cfg_pkg.sv
// Shared types and constants for the serial configuration loader.
package cfg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_CHECK = 2'd3
    } state_t;

    localparam logic [7:0] CRC8_POLY = 8'h07;
    localparam logic [7:0] CRC8_INIT = 8'h00;

    // One serial CRC-8 step: feedback is the outgoing MSB xor the new bit.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
        logic fb;
        fb = crc[7] ^ din;
        return {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/cfg_crc8.sv
// Serial CRC-8 accumulator over the bits driven onto the config chain.
module cfg_crc8
    import cfg_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       en,
    input  logic       din,
    output logic [7:0] crc
);

    // Clear has priority over update so a new load always starts from init.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            crc <= CRC8_INIT;
        end else if (clr) begin
            crc <= CRC8_INIT;
        end else if (en) begin
            crc <= crc8_step(crc, din);
        end
    end

endmodule

// File: rtl/cfg_loader.sv
// Byte-wide to serial config chain loader with trailing CRC-8 check.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start; chain untouched
// ST_LOAD  | in_ready high, waiting for the next config byte
// ST_SHIFT | driving one bit per cycle onto the chain, MSB first
// ST_CHECK | in_ready high, waiting for the CRC byte to compare
module cfg_loader
    import cfg_pkg::*;
#(
    parameter int CHAIN_LEN = 8,
    parameter int DW        = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          cfg_si,
    output logic          cfg_shift_en,
    output logic          busy,
    output logic          done,
    output logic          crc_err
);

    localparam int CW = $clog2(CHAIN_LEN + 1);

    state_t        state;
    state_t        state_nxt;
    logic [DW-1:0] shreg;
    logic [3:0]    bit_left;
    logic [CW-1:0] bits_done;
    logic [CW-1:0] bits_rem;
    logic [3:0]    byte_bits;
    logic [7:0]    crc;
    logic          start_ok;
    logic          accept;
    logic          last_bit;
    logic          more_bits;

    // Bits still owed to the chain decide how much of the next byte is used;
    // a final partial byte keeps only its upper bits.
    assign bits_rem  = CW'(CHAIN_LEN) - bits_done;
    assign byte_bits = (32'(bits_rem) >= 32'd8) ? 4'd8 : 4'(bits_rem);
    assign last_bit  = (bit_left == 4'd1);
    assign more_bits = (32'(bits_done) + 32'd1) < 32'(CHAIN_LEN);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake/chain outputs; abort overrides everything.
    always_comb begin
        state_nxt    = state;
        in_ready     = 1'b0;
        cfg_shift_en = 1'b0;
        cfg_si       = 1'b0;
        start_ok     = 1'b0;
        accept       = 1'b0;
        busy         = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (start) begin
                    start_ok  = 1'b1;
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept    = 1'b1;
                    state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                cfg_shift_en = 1'b1;
                cfg_si       = shreg[DW-1];
                if (last_bit) begin
                    state_nxt = more_bits ? ST_LOAD : ST_CHECK;
                end
            end
            ST_CHECK: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept    = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (abort) begin
            state_nxt = ST_IDLE;
            start_ok  = 1'b0;
            accept    = 1'b0;
        end
    end

    // Datapath: byte capture, per-byte down-counter, saturating bit count, status flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shreg     <= '0;
            bit_left  <= 4'd0;
            bits_done <= '0;
            done      <= 1'b0;
            crc_err   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start_ok) begin
                bits_done <= '0;
                crc_err   <= 1'b0;
            end
            if (accept && state == ST_LOAD) begin
                shreg    <= in_data;
                bit_left <= byte_bits;
            end
            if (accept && state == ST_CHECK) begin
                done <= 1'b1;
                if (in_data != crc) begin
                    crc_err <= 1'b1;
                end
            end
            if (cfg_shift_en) begin
                shreg    <= {shreg[DW-2:0], 1'b0};
                bit_left <= bit_left - 4'd1;
                if (bits_done != CW'(CHAIN_LEN)) begin
                    bits_done <= bits_done + CW'(1);
                end
            end
        end
    end

    cfg_crc8 u_crc8 (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start_ok),
        .en    (cfg_shift_en),
        .din   (cfg_si),
        .crc   (crc)
    );

endmodule

// File: tb/tb_cfg_loader.sv
// Directed bench for cfg_loader: an 8-bit chain instance and a 12-bit chain instance.
module tb_cfg_loader;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       a_start, a_abort, a_in_valid;
    logic [7:0] a_in_data;
    logic       a_in_ready, a_cfg_si, a_cfg_shift_en, a_busy, a_done, a_crc_err;

    logic       b_start, b_abort, b_in_valid;
    logic [7:0] b_in_data;
    logic       b_in_ready, b_cfg_si, b_cfg_shift_en, b_busy, b_done, b_crc_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cfg_loader #(.CHAIN_LEN(8), .DW(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(a_start), .abort(a_abort),
        .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .cfg_si(a_cfg_si), .cfg_shift_en(a_cfg_shift_en), .busy(a_busy),
        .done(a_done), .crc_err(a_crc_err)
    );

    cfg_loader #(.CHAIN_LEN(12), .DW(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .abort(b_abort),
        .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .cfg_si(b_cfg_si), .cfg_shift_en(b_cfg_shift_en), .busy(b_busy),
        .done(b_done), .crc_err(b_crc_err)
    );

    task automatic test_reset();
        rst_n = 1'b0;
        a_start = 0; a_abort = 0; a_in_valid = 0; a_in_data = 8'h00;
        b_start = 0; b_abort = 0; b_in_valid = 0; b_in_data = 8'h00;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({a_in_ready, a_cfg_si, a_cfg_shift_en, a_busy, a_done, a_crc_err} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_a: outputs=%b expected 000000",
                     {a_in_ready, a_cfg_si, a_cfg_shift_en, a_busy, a_done, a_crc_err});
        end
        n_checks++;
        if ({b_in_ready, b_cfg_si, b_cfg_shift_en, b_busy, b_done, b_crc_err} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_b: outputs=%b expected 000000",
                     {b_in_ready, b_cfg_si, b_cfg_shift_en, b_busy, b_done, b_crc_err});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_load_a(input logic [7:0] d, input logic [7:0] c, input logic exp_err,
                               input string name);
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        n_checks++;
        if (a_in_ready !== 1'b1 || a_busy !== 1'b1 || a_cfg_shift_en !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_load: in_ready=%b busy=%b shift_en=%b expected 1 1 0",
                     name, a_in_ready, a_busy, a_cfg_shift_en);
        end
        a_in_data  = d;
        a_in_valid = 1'b1;
        @(negedge clk);
        a_in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (a_cfg_shift_en !== 1'b1 || a_cfg_si !== d[7-i] || a_in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL %s_shift%0d: shift_en=%b si=%b in_ready=%b expected 1 %b 0",
                         name, i, a_cfg_shift_en, a_cfg_si, a_in_ready, d[7-i]);
            end
            @(negedge clk);
        end
        n_checks++;
        if (a_cfg_shift_en !== 1'b0 || a_in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_check_state: shift_en=%b in_ready=%b expected 0 1",
                     name, a_cfg_shift_en, a_in_ready);
        end
        a_in_data  = c;
        a_in_valid = 1'b1;
        @(negedge clk);
        a_in_valid = 1'b0;
        n_checks++;
        if (a_done !== 1'b1 || a_busy !== 1'b0 || a_crc_err !== exp_err) begin
            n_fail++;
            $display("FAIL %s_done: done=%b busy=%b crc_err=%b expected 1 0 %b",
                     name, a_done, a_busy, a_crc_err, exp_err);
        end
        @(negedge clk);
        n_checks++;
        if (a_done !== 1'b0 || a_crc_err !== exp_err) begin
            n_fail++;
            $display("FAIL %s_after: done=%b crc_err=%b expected 0 %b",
                     name, a_done, a_crc_err, exp_err);
        end
    endtask

    task automatic test_sticky_err();
        test_load_a(8'hA5, 8'h00, 1'b1, "bad_crc");
        repeat (3) @(negedge clk);
        n_checks++;
        if (a_crc_err !== 1'b1) begin
            n_fail++;
            $display("FAIL sticky_hold: crc_err=%b expected 1", a_crc_err);
        end
        a_start = 1'b1;
        a_abort = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        a_abort = 1'b0;
        n_checks++;
        if (a_busy !== 1'b0 || a_crc_err !== 1'b1) begin
            n_fail++;
            $display("FAIL start_abort_idle: busy=%b crc_err=%b expected 0 1", a_busy, a_crc_err);
        end
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        n_checks++;
        if (a_busy !== 1'b1 || a_crc_err !== 1'b0) begin
            n_fail++;
            $display("FAIL sticky_clear: busy=%b crc_err=%b expected 1 0", a_busy, a_crc_err);
        end
        a_abort = 1'b1;
        @(negedge clk);
        a_abort = 1'b0;
        n_checks++;
        if (a_busy !== 1'b0 || a_in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_load: busy=%b in_ready=%b expected 0 0", a_busy, a_in_ready);
        end
    endtask

    task automatic test_abort_shift();
        a_start = 1'b1;
        @(negedge clk);
        a_start    = 1'b0;
        a_in_data  = 8'hA5;
        a_in_valid = 1'b1;
        @(negedge clk);
        a_in_valid = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (a_cfg_shift_en !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_third_shift: shift_en=%b expected 1", a_cfg_shift_en);
        end
        a_abort = 1'b1;
        @(negedge clk);
        a_abort = 1'b0;
        n_checks++;
        if (a_cfg_shift_en !== 1'b0 || a_busy !== 1'b0 || a_in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_shift: shift_en=%b busy=%b in_ready=%b expected 0 0 0",
                     a_cfg_shift_en, a_busy, a_in_ready);
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (a_done !== 1'b0 || a_cfg_shift_en !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_quiet%0d: done=%b shift_en=%b expected 0 0",
                         i, a_done, a_cfg_shift_en);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_stall();
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (a_in_ready !== 1'b1 || a_cfg_shift_en !== 1'b0 || a_busy !== 1'b1) begin
                n_fail++;
                $display("FAIL stall%0d: in_ready=%b shift_en=%b busy=%b expected 1 0 1",
                         i, a_in_ready, a_cfg_shift_en, a_busy);
            end
            a_start = (i == 2);
            @(negedge clk);
        end
        a_start    = 1'b0;
        a_in_data  = 8'h3C;
        a_in_valid = 1'b1;
        @(negedge clk);
        a_in_valid = 1'b0;
        a_start    = 1'b1;
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (a_cfg_shift_en !== 1'b1 || a_cfg_si !== ((8'h3C >> (7 - i)) & 8'h01)) begin
                n_fail++;
                $display("FAIL stall_shift%0d: shift_en=%b si=%b", i, a_cfg_shift_en, a_cfg_si);
            end
            @(negedge clk);
            a_start = 1'b0;
        end
        // CRC-8/0x07 of 0x3C is 0xB4.
        a_in_data  = 8'hB4;
        a_in_valid = 1'b1;
        @(negedge clk);
        a_in_valid = 1'b0;
        n_checks++;
        if (a_done !== 1'b1 || a_crc_err !== 1'b0 || a_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_done: done=%b crc_err=%b busy=%b expected 1 0 0",
                     a_done, a_crc_err, a_busy);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_shift();
        a_start = 1'b1;
        @(negedge clk);
        a_start    = 1'b0;
        a_in_data  = 8'hA5;
        a_in_valid = 1'b1;
        @(negedge clk);
        a_in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({a_in_ready, a_cfg_si, a_cfg_shift_en, a_busy, a_done, a_crc_err} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_mid_shift: outputs=%b expected 000000",
                     {a_in_ready, a_cfg_si, a_cfg_shift_en, a_busy, a_done, a_crc_err});
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (a_done !== 1'b0 || a_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_no_done: done=%b busy=%b expected 0 0", a_done, a_busy);
        end
        test_load_a(8'hA5, 8'h72, 1'b0, "post_reset");
    endtask

    task automatic test_chain12();
        int ones;
        int shifts;
        logic [7:0] bytes_in [2];
        bytes_in[0] = 8'hFF;
        bytes_in[1] = 8'hF0;
        ones   = 0;
        shifts = 0;
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (b_in_ready !== 1'b1 || b_cfg_shift_en !== 1'b0) begin
                n_fail++;
                $display("FAIL c12_load%0d: in_ready=%b shift_en=%b expected 1 0",
                         k, b_in_ready, b_cfg_shift_en);
            end
            b_in_data  = bytes_in[k];
            b_in_valid = 1'b1;
            @(negedge clk);
            b_in_valid = 1'b0;
            for (int i = 0; i < ((k == 0) ? 8 : 4); i++) begin
                n_checks++;
                if (b_cfg_shift_en !== 1'b1 || b_cfg_si !== 1'b1 || b_in_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL c12_shift%0d_%0d: shift_en=%b si=%b in_ready=%b expected 1 1 0",
                             k, i, b_cfg_shift_en, b_cfg_si, b_in_ready);
                end
                if (b_cfg_shift_en === 1'b1) begin
                    shifts++;
                    if (b_cfg_si === 1'b1) ones++;
                end
                @(negedge clk);
            end
        end
        n_checks++;
        if (b_cfg_shift_en !== 1'b0 || b_in_ready !== 1'b1 || shifts != 12 || ones != 12) begin
            n_fail++;
            $display("FAIL c12_check_state: shift_en=%b in_ready=%b shifts=%0d ones=%0d expected 0 1 12 12",
                     b_cfg_shift_en, b_in_ready, shifts, ones);
        end
        // CRC-8/0x07 over twelve 1 bits is 0x30.
        b_in_data  = 8'h30;
        b_in_valid = 1'b1;
        @(negedge clk);
        b_in_valid = 1'b0;
        n_checks++;
        if (b_done !== 1'b1 || b_crc_err !== 1'b0 || b_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL c12_done: done=%b crc_err=%b busy=%b expected 1 0 0",
                     b_done, b_crc_err, b_busy);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_load_a(8'hA5, 8'h72, 1'b0, "good_crc");
        test_sticky_err();
        test_abort_shift();
        test_stall();
        test_reset_mid_shift();
        test_chain12();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cfg_loader.md
CFG_LOADER -- requirements
Module: cfg_loader

Interface
REQ-001 Parameter: CHAIN_LEN, default 8, total config bits in the downstream serial chain (>=1).
REQ-002 Parameter: DW, fixed 8, width of the input data bus.
REQ-003 Port: clk  in  1  single clock for all logic, rising edge.
REQ-004 Port: rst_n  in  1  synchronous, active-low reset.
REQ-005 Port: start  in  1  one-cycle request to begin a load; honoured only in IDLE.
REQ-006 Port: abort  in  1  returns to IDLE at the next edge, from any state.
REQ-007 Port: in_data  in  8  config byte, MSB shifted first.
REQ-008 Port: in_valid  in  1  in_data valid.
REQ-009 Port: in_ready  out  1  loader accepts in_data this cycle.
REQ-010 Port: cfg_si  out  1  serial data to the chain's si.
REQ-011 Port: cfg_shift_en  out  1  chain shift-enable; chain advances one bit per cycle while high.
REQ-012 Port: busy  out  1  high in every state except IDLE.
REQ-013 Port: done  out  1  one-cycle pulse at load completion.
REQ-014 Port: crc_err  out  1  sticky CRC mismatch flag.

Function
REQ-015 States: IDLE, LOAD, SHIFT, CHECK; in any state, abort=1 forces IDLE next cycle with cfg_shift_en=0.
REQ-016 IDLE: start=1 -> LOAD; bit counter and CRC cleared to 0; crc_err cleared.
REQ-017 LOAD: in_ready=1; a transfer occurs when in_valid & in_ready; the byte is captured and the state goes to SHIFT.
REQ-018 SHIFT count: per byte = min(8, CHAIN_LEN - bits_done).
REQ-019 SHIFT order: MSB first; in a final partial byte, only the upper bits are used and the low bits are discarded.
REQ-020 Shift timing: a byte accepted in cycle N drives cfg_shift_en=1 in cycles N+1..N+k, where k is the per-byte count; cfg_si is valid in the same cycles.
REQ-021 SHIFT exit: after the last bit of a byte, go to LOAD if bits_done < CHAIN_LEN, else CHECK.
REQ-022 Throughput: in_ready=0 throughout SHIFT; a full byte costs 9 cycles.
REQ-023 CRC: CRC-8, poly 0x07, init 0x00, updated serially with each bit driven while cfg_shift_en=1.
REQ-024 CHECK: in_ready=1; the accepted byte is compared with the CRC.
REQ-025 CHECK result: next cycle the state is IDLE, done pulses, and crc_err=1 if the compare mismatched.
REQ-026 No input data is consumed in IDLE; in_ready=0 in IDLE and SHIFT.
REQ-027 start while busy is ignored; start and abort asserted together in IDLE resolve to abort (stay IDLE).
REQ-028 Bit counter width is $clog2(CHAIN_LEN+1); the counter saturates at CHAIN_LEN and never wraps.
REQ-029 cfg_shift_en=0 in IDLE, LOAD and CHECK, so the chain holds its contents.

Reset
REQ-030 rst_n=0 at a clock edge: state=IDLE, in_ready=0, cfg_si=0, cfg_shift_en=0, busy=0, done=0, crc_err=0, counters and CRC cleared.
REQ-031 Reset mid-SHIFT stops shifting at that edge; the chain contents are left partially loaded and no done pulse is produced.

Structure
REQ-032 Shared package cfg_pkg: state enum, CRC8_POLY=8'h07, CRC8_INIT=8'h00.
REQ-033 Sub-module cfg_crc8: serial CRC-8 register with clr, en and din inputs and an 8-bit crc output, instantiated once.

Verification
REQ-034 CHAIN_LEN=8, start, byte 0xA5, then CRC 0x72 -> cfg_shift_en high for 8 cycles, cfg_si=1,0,1,0,0,1,0,1; done pulse; crc_err=0.
REQ-035 As REQ-034 but CRC byte 0x00 -> done pulse and crc_err=1; crc_err stays 1 until the next accepted start.
REQ-036 CHAIN_LEN=12, bytes 0xFF, 0xF0 -> 8 then 4 shift cycles; the chain receives 12 ones; the low nibble of the second byte is never driven.
REQ-037 abort asserted on the 3rd SHIFT cycle -> cfg_shift_en=0 next cycle, state IDLE, busy=0, no done pulse.
REQ-038 in_valid held low for 5 cycles in LOAD -> in_ready stays 1 and cfg_shift_en stays 0; a start pulse while busy has no effect.
REQ-039 rst_n=0 during SHIFT -> all outputs at their reset values next cycle; a subsequent clean load of 0xA5/0x72 completes with crc_err=0.
